data_sram_responder: RTL

- SRAM-like slave that serves the CPU data-port request/response interface, i.e. the responder end of the path the memory stage consumes `data_sram_rdata` from.
- Sits between mycpu_top's data port and a local word-addressed memory array; used in bench and FPGA builds in place of the fixed one-cycle data SRAM.
- Accepts requests with an `addr_ok` handshake.
- Returns in-order responses with `data_ok` after a programmable latency, tolerating multiple outstanding requests.

---
 rtl/data_sram_responder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/data_sram_responder.sv
// Word-addressed SRAM slave: accept on addr_ok, in-order data_ok LATENCY cycles later, up to DEPTH outstanding.
// No response backpressure; `DSRAM_RAND_DELAY_EN adds an LFSR-driven 0..3 extra cycles per request.
module data_sram_responder #(
  parameter int ADDR_WIDTH = 14,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
`ifdef DSRAM_RAND_DELAY_EN
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 3;
`endif

  typedef logic [PTR_W-1:0] ptr_t;

  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(LATENCY - 1);
  localparam ptr_t             LAST_PTR  = PTR_W'(DEPTH - 1);

  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] word_idx;

  logic                  q_vld   [DEPTH];
  logic [CNT_W-1:0]      q_cnt   [DEPTH];
  logic [31:0]           q_rdata [DEPTH];
  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;
  logic [OCC_W-1:0]      count;

  logic                  accept;
  logic                  pop;
  logic [CNT_W-1:0]      push_cnt;
  logic [31:0]           push_rdata;

  logic                  unused_ok;
  assign unused_ok = ^{data_sram_size, data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

  function automatic ptr_t ptr_next(input ptr_t p);
    return (p == LAST_PTR) ? '0 : ptr_t'(p + 1'b1);
  endfunction

  assign word_idx = data_sram_addr[ADDR_WIDTH+1:2];

  // No pop-through: a full queue refuses even when the head retires this cycle.
  assign data_sram_addr_ok = resetn && (count < DEPTH_OCC);
  assign data_sram_data_ok = q_vld[rd_ptr] && (q_cnt[rd_ptr] == '0);
  assign data_sram_rdata   = data_sram_data_ok ? q_rdata[rd_ptr] : '0;

  assign accept     = data_sram_req && data_sram_addr_ok;
  assign pop        = data_sram_data_ok;
  assign push_rdata = data_sram_wr ? 32'h0 : mem[word_idx];

`ifdef DSRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= 8'hA5;
    else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign push_cnt = CNT_INIT + {{(CNT_W-2){1'b0}}, lfsr[1:0]};
`else
  assign push_cnt = CNT_INIT;
`endif

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) mem[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_vld[i]   <= 1'b0;
        q_cnt[i]   <= '0;
        q_rdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_vld[i] && (q_cnt[i] != '0)) q_cnt[i] <= q_cnt[i] - 1'b1;
      end
      if (pop) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= ptr_next(rd_ptr);
      end
      // The write slot is never the popping slot, since accept implies a free entry.
      if (accept) begin
        q_vld[wr_ptr]   <= 1'b1;
        q_cnt[wr_ptr]   <= push_cnt;
        q_rdata[wr_ptr] <= push_rdata;
        wr_ptr          <= ptr_next(wr_ptr);
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
